// File: rtl/edge_scan_scheduler.sv
// Frame-level edge-row scheduler: picks the scanned row per frame, snapshots and reduces
// measured_list to first/last/width/count. Optional row sweep enabled by `define ROW_SWEEP_EN.
module edge_scan_scheduler #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned N_EDGES = 30
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      sop,
    input  logic                      packet_video,
    input  logic                      in_valid,
    input  logic [10:0]               x,
    input  logic [10:0]               y,
    input  logic [10:0]               cfg_row_start,
    input  logic [10:0]               cfg_row_step,
    input  logic [5:0]                cfg_row_count,
    input  logic [N_EDGES-1:0][10:0]  measured_list,
    output logic [10:0]               edge_row,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [10:0]               res_row,
    output logic [10:0]               res_first,
    output logic [10:0]               res_last,
    output logic [10:0]               res_width,
    output logic [5:0]                res_count,
    output logic [7:0]                overrun_cnt,
    output logic                      busy
);

    localparam int unsigned RW = $clog2(N_EDGES);
    localparam logic [RW-1:0] LAST_IDX = RW'(N_EDGES - 1);

    typedef enum logic [2:0] {IDLE, ARM, SCAN, SNAP, REDUCE, PRESENT} state_t;

    state_t                     state, state_n;
    logic [N_EDGES-1:0][10:0]   snap;
    logic [10:0]                snap_row;
    logic [RW-1:0]              ridx;
    logic [10:0]                run_min, run_max;
    logic [5:0]                 run_cnt;
    logic [10:0]                cur;
    logic                       video_sop, frame_end, in_result;

    assign video_sop = sop && packet_video;
    assign frame_end = in_valid && (x == 11'(IMG_W - 1)) && (y == 11'(IMG_H - 1));
    assign in_result = (state == SNAP) || (state == REDUCE) || (state == PRESENT);
    assign cur       = snap[ridx];
    assign busy      = (state != IDLE);

`ifdef ROW_SWEEP_EN
    logic [5:0]  row_idx;
    logic [5:0]  cnt_eff, idx_n;
    logic [11:0] row_sum;
    assign cnt_eff = (cfg_row_count == 6'd0) ? 6'd1 : cfg_row_count;
    assign idx_n   = row_idx + 6'd1;
    assign row_sum = {1'b0, edge_row} + {1'b0, cfg_row_step};
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_row_step, cfg_row_count};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = ARM;
            ARM:     if (!enable) state_n = IDLE;
                     else if (video_sop) state_n = SCAN;
            SCAN:    if (frame_end) state_n = SNAP;
            SNAP:    state_n = REDUCE;
            REDUCE:  if (ridx == LAST_IDX) state_n = PRESENT;
            PRESENT: if (res_valid && res_ready) state_n = enable ? ARM : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_row    <= cfg_row_start;
            res_valid   <= 1'b0;
            res_row     <= '0;
            res_first   <= '0;
            res_last    <= '0;
            res_width   <= '0;
            res_count   <= '0;
            overrun_cnt <= '0;
            snap_row    <= '0;
            ridx        <= '0;
            run_min     <= '1;
            run_max     <= '0;
            run_cnt     <= '0;
`ifdef ROW_SWEEP_EN
            row_idx     <= '0;
`endif
        end else begin
            if (video_sop && in_result && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE: if (enable) begin
                    edge_row <= cfg_row_start;
`ifdef ROW_SWEEP_EN
                    row_idx  <= '0;
`endif
                end
                SNAP: begin
                    snap     <= measured_list;
                    snap_row <= edge_row;
                    ridx     <= '0;
                    run_min  <= '1;
                    run_max  <= '0;
                    run_cnt  <= '0;
`ifdef ROW_SWEEP_EN
                    // Count wrap and image-bottom wrap both restart the sweep
                    if (idx_n >= cnt_eff || row_sum >= 12'(IMG_H)) begin
                        edge_row <= cfg_row_start;
                        row_idx  <= '0;
                    end else begin
                        edge_row <= row_sum[10:0];
                        row_idx  <= idx_n;
                    end
`else
                    edge_row <= cfg_row_start;
`endif
                end
                REDUCE: begin
                    if (cur != 11'd0) begin
                        if (cur < run_min) run_min <= cur;
                        if (cur > run_max) run_max <= cur;
                        run_cnt <= run_cnt + 6'd1;
                    end
                    ridx <= ridx + 1'b1;
                end
                PRESENT: begin
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_row   <= snap_row;
                        res_count <= run_cnt;
                        if (run_cnt == 6'd0) begin
                            res_first <= '0;
                            res_last  <= '0;
                            res_width <= '0;
                        end else begin
                            res_first <= run_min;
                            res_last  <= run_max;
                            res_width <= run_max - run_min;
                        end
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_scan_scheduler.sv
// Directed self-checking bench for edge_scan_scheduler; row expectations follow ROW_SWEEP_EN.
module tb_edge_scan_scheduler;

    logic                clk = 1'b0;
    logic                reset_n, enable, sop, packet_video, in_valid, res_ready;
    logic [10:0]         x, y, cfg_row_start, cfg_row_step;
    logic [5:0]          cfg_row_count;
    logic [29:0][10:0]   ml;
    logic [10:0]         edge_row, res_row, res_first, res_last, res_width;
    logic                res_valid, busy;
    logic [5:0]          res_count;
    logic [7:0]          overrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    edge_scan_scheduler #(.IMG_W(640), .IMG_H(480), .N_EDGES(30)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sop(sop),
        .packet_video(packet_video), .in_valid(in_valid), .x(x), .y(y),
        .cfg_row_start(cfg_row_start), .cfg_row_step(cfg_row_step),
        .cfg_row_count(cfg_row_count), .measured_list(ml), .edge_row(edge_row),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_first(res_first), .res_last(res_last), .res_width(res_width),
        .res_count(res_count), .overrun_cnt(overrun_cnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_sop(input logic video);
        sop = 1'b1; packet_video = video;
        tick();
        sop = 1'b0; packet_video = 1'b0;
    endtask

    task automatic frame_end();
        in_valid = 1'b1; x = 11'd639; y = 11'd479;
        tick();
        in_valid = 1'b0; x = 11'd0; y = 11'd0;
    endtask

    // Called with edges elapsed since frame end; result must appear after exactly 32
    task automatic wait_valid(input int start_lat);
        int lat = start_lat;
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", lat, 32);
    endtask

    task automatic do_frame();
        pulse_sop(1'b1);
        tick();
        frame_end();
        wait_valid(0);
    endtask

    logic [10:0] exp_rows [4];

    initial begin
        reset_n = 1'b0; enable = 1'b0; sop = 1'b0; packet_video = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; res_ready = 1'b1;
        cfg_row_start = 11'd240; cfg_row_step = 11'd0; cfg_row_count = 6'd1;
        ml = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_row", edge_row, 240);
        check("rst_count", res_count, 0);
        reset_n = 1'b1;

        // Three nonzero entries scattered, minimum not first
        enable = 1'b1;
        tick();
        check("arm_busy", busy, 1);
        ml[2] = 11'd400; ml[5] = 11'd150; ml[10] = 11'd100;
        do_frame();
        check("f1_first", res_first, 100);
        check("f1_last", res_last, 400);
        check("f1_width", res_width, 300);
        check("f1_count", res_count, 3);
        check("f1_row", res_row, 240);
        tick();
        check("f1_drop", res_valid, 0);

        // All-zero list
        ml = '0;
        do_frame();
        check("z_valid", res_valid, 1);
        check("z_first", res_first, 0);
        check("z_last", res_last, 0);
        check("z_width", res_width, 0);
        check("z_count", res_count, 0);
        tick();

        // Sweep 200/20/3
        enable = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        cfg_row_start = 11'd200; cfg_row_step = 11'd20; cfg_row_count = 6'd3;
        enable = 1'b1;
        tick();
`ifdef ROW_SWEEP_EN
        exp_rows = '{11'd200, 11'd220, 11'd240, 11'd200};
`else
        exp_rows = '{11'd200, 11'd200, 11'd200, 11'd200};
`endif
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_pre%0d", i), edge_row, exp_rows[i]);
            do_frame();
            check($sformatf("sw_res%0d", i), res_row, exp_rows[i]);
            tick();
        end

`ifndef ROW_SWEEP_EN
        // Start row resampled at SNAP, held during SCAN
        pulse_sop(1'b1);
        cfg_row_start = 11'd300;
        tick();
        check("hold_scan", edge_row, 200);
        frame_end();
        tick();
        check("resample", edge_row, 300);
        wait_valid(1);
        check("resample_res", res_row, 200);
        tick();
`endif

        // Wrap on bottom of image: 470+20 >= 480
        enable = 1'b0;
        tick();
        cfg_row_start = 11'd470;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wrap_pre%0d", i), edge_row, 470);
            do_frame();
            check($sformatf("wrap_res%0d", i), res_row, 470);
            tick();
        end

        // Overrun with consumer stalled; boundary entries 0 and 29
        res_ready = 1'b0;
        ml = '0; ml[0] = 11'd1; ml[3] = 11'd7; ml[29] = 11'd639;
        do_frame();
        tick();
        pulse_sop(1'b1);
        tick(); tick(); tick();
        pulse_sop(1'b1);
        tick();
        check("ov_cnt", overrun_cnt, 2);
        check("ov_valid", res_valid, 1);
        check("ov_first", res_first, 1);
        check("ov_last", res_last, 639);
        check("ov_width", res_width, 638);
        check("ov_count", res_count, 3);
        check("ov_row", res_row, 470);
        res_ready = 1'b1;
        tick();
        check("ov_xfer", res_valid, 0);
        ml = '0;
        do_frame();
        check("post_ov_count", res_count, 0);
        check("post_ov_cnt", overrun_cnt, 2);
        tick();

        // Non-video sop in ARM must not start a scan
        pulse_sop(1'b0);
        tick();
        frame_end();
        for (int i = 0; i < 40; i++) tick();
        check("nv_valid", res_valid, 0);
        check("nv_busy", busy, 1);
        enable = 1'b0;
        tick();
        check("nv_idle", busy, 0);

        // Reset in the middle of REDUCE
        enable = 1'b1;
        tick();
        do begin
            pulse_sop(1'b1);
            tick();
            frame_end();
        end while (0);
        for (int i = 0; i < 10; i++) tick();
        cfg_row_start = 11'd123;
        reset_n = 1'b0;
        tick();
        check("mid_busy", busy, 0);
        check("mid_valid", res_valid, 0);
        check("mid_overrun", overrun_cnt, 0);
        check("mid_row", edge_row, 123);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
